pattern_seq_tx: RTL and testbench
=================================

Name: pattern_seq_tx

Overview:
Moore-style serial pattern transmitter: loads a W-bit pattern and shifts it out MSB-first on a 1-bit line, repeated a programmable number of times with optional inter-pattern gap bits. It produces the serial stimulus stream consumed by the team's Moore sequence detectors. With a gap of 0 it produces back-to-back overlapping occurrences; with a gap it produces separated occurrences. A start/busy/done handshake lets a controller or bench launch a burst and wait for completion.

Parameters:
W, 4, pattern width in bits (2..16).
IDLE_BIT, 1'b0, value driven on dout when not transmitting.

Ports:
clk  input  1  clock, all state changes on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  launch request; sampled only in IDLE.
abort  input  1  synchronous abort; returns the block to IDLE.
pattern  input  W  pattern to send, MSB first; latched on start acceptance.
reps  input  8  number of pattern repetitions; latched on start acceptance.
gap  input  4  number of gap bits between repetitions; latched on start acceptance.
gap_bit  input  1  value driven during gap bits; latched on start acceptance.
dout  output  1  serial data, registered.
dvalid  output  1  high while dout carries a pattern bit.
busy  output  1  high from acceptance until the DONE state.
done  output  1  one-cycle pulse at burst completion.
sent_cnt  output  8  completed repetitions in the current or last burst.

Behaviour:
- Reset (async, rst=1): state=IDLE; dout=IDLE_BIT; dvalid=0; busy=0; done=0; sent_cnt=0; internal counters=0. Outputs take these values immediately, without waiting for a clock edge, including mid-burst.
- States (one-hot): IDLE, SHIFT, GAP, DONE. All outputs are decoded from registered state, shift register and counters (Moore). No output depends combinationally on an input.
- IDLE: dout=IDLE_BIT, dvalid=0, busy=0.
  - start=1 at edge E0 with reps!=0: latch pattern, reps, gap and gap_bit; clear sent_cnt; bit_idx=W-1; go to SHIFT.
  - start=1 with reps=0: go to DONE; sent_cnt=0; no bits are sent.
- SHIFT: dout=shreg[W-1], dvalid=1, busy=1. Shift left each cycle. The first pattern bit appears in the cycle after E0, so latency is 1 cycle.
  - After the W-th bit: sent_cnt increments.
  - If this was the last repetition, go to DONE.
  - Else if gap!=0, go to GAP with gap_cnt=gap.
  - Else reload the pattern and stay in SHIFT. Repetitions are contiguous with no idle cycle between them.
- GAP: dout=gap_bit, dvalid=0, busy=1. Stays for exactly gap cycles, then reloads the pattern and goes to SHIFT.
- DONE: exactly one cycle; done=1, busy=0, dvalid=0, dout=IDLE_BIT. Then go to IDLE. sent_cnt holds until the next accepted start.
- start is ignored in SHIFT, GAP and DONE. Changes to pattern, reps, gap or gap_bit after acceptance have no effect.
- abort=1 in any non-IDLE state: go to IDLE at the next edge with no done pulse; sent_cnt holds its partial count. abort has priority over all transitions. In IDLE, abort has priority over start.
- Burst length in dout cycles is reps*W + (reps-1)*gap, followed by 1 DONE cycle. sent_cnt cannot overflow (reps ≤ 255).

Decomposition:
- Package pattern_seq_pkg holds:
  - the one-hot state constants (IDLE=4'b0001, SHIFT=4'b0010, GAP=4'b0100, DONE=4'b1000);
  - the counter widths (bit index $clog2(W), gap 4, reps 8).
- One sub-module, seq_tx_shreg: a W-bit parallel-load, shift-left register with serial output at the MSB and a load/shift enable. The top level contains the FSM and the counters.

Test Plan:
- Reset mid-burst: assert rst 3 cycles into a burst -> dout=IDLE_BIT, busy=0, dvalid=0 immediately. After release the block stays IDLE until a new start.
- Basic: pattern=4'b1011, reps=1, gap=0, start pulse -> dout=1,0,1,1 on cycles 1..4 with dvalid=1, done=1 on cycle 5, sent_cnt=1, busy high for cycles 1..4.
- Contiguous: pattern=1011, reps=3, gap=0 -> 12 contiguous bits 101110111011, done on cycle 13, sent_cnt=3. A connected overlapping 1011 detector pulses 3 times.
- Gap: pattern=1101, reps=2, gap=2, gap_bit=0 -> dout=1101 00 1101, dvalid low on the 2 gap cycles, done on cycle 11.
- Edge cases:
  - reps=0 -> done on cycle 1, dvalid never high, sent_cnt=0.
  - start held high through a burst -> exactly one burst per acceptance, the next burst starts the cycle after DONE.
- Abort: abort during the 2nd repetition of a reps=4 burst -> IDLE next edge, no done pulse, sent_cnt=1.

Source files
------------

// File: rtl/pattern_seq_pkg.sv
// Shared types and widths for the serial pattern transmitter.
package pattern_seq_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    SHIFT = 4'b0010,
    GAP   = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  localparam int unsigned GAP_CW  = 4;
  localparam int unsigned REPS_CW = 8;

  // Bit-index counter width for a W-bit pattern (at least one bit).
  function automatic int unsigned idx_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// W-bit parallel-load, shift-left register; serial output is the MSB.
module seq_tx_shreg #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (load)  q <= din;
    else if (shift) q <= {q[W-2:0], 1'b0};
  end

  assign msb = q[W-1];

endmodule

// File: rtl/pattern_seq_tx.sv
// Moore serial pattern transmitter: repeats a W-bit pattern MSB-first with optional gap bits.
module pattern_seq_tx
  import pattern_seq_pkg::*;
#(
  parameter int unsigned W        = 4,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [W-1:0]       pattern,
  input  logic [REPS_CW-1:0] reps,
  input  logic [GAP_CW-1:0]  gap,
  input  logic               gap_bit,
  output logic               dout,
  output logic               dvalid,
  output logic               busy,
  output logic               done,
  output logic [REPS_CW-1:0] sent_cnt
);

  localparam int unsigned        IDX_W    = idx_width(W);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(W - 1);

  state_t state_q, state_d;

  logic [W-1:0]       pat_q;
  logic [REPS_CW-1:0] reps_q, sent_q;
  logic [GAP_CW-1:0]  gap_q, gap_cnt_q;
  logic               gap_bit_q;
  logic [IDX_W-1:0]   idx_q;

  logic accept, clr_sent, inc_sent;
  logic sh_load, sh_shift, idx_load, gap_load, gap_dec;
  logic [W-1:0] sh_din;
  logic sh_msb;

  // First load comes straight from the port; later reloads use the latched copy.
  assign sh_din = (state_q == IDLE) ? pattern : pat_q;

  seq_tx_shreg #(.W(W)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (sh_din),
    .msb   (sh_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    clr_sent = 1'b0;
    inc_sent = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    idx_load = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            clr_sent = 1'b1;
            if (reps == '0) begin
              state_d = DONE;
            end else begin
              accept   = 1'b1;
              sh_load  = 1'b1;
              idx_load = 1'b1;
              state_d  = SHIFT;
            end
          end
        end
        SHIFT: begin
          if (idx_q == '0) begin
            inc_sent = 1'b1;
            if (REPS_CW'(sent_q + 1'b1) == reps_q) begin
              state_d = DONE;
            end else if (gap_q != '0) begin
              gap_load = 1'b1;
              state_d  = GAP;
            end else begin
              sh_load  = 1'b1;
              idx_load = 1'b1;
            end
          end else begin
            sh_shift = 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_CW'(1)) begin
            sh_load  = 1'b1;
            idx_load = 1'b1;
            state_d  = SHIFT;
          end else begin
            gap_dec = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q     <= '0;
      reps_q    <= '0;
      gap_q     <= '0;
      gap_bit_q <= 1'b0;
      sent_q    <= '0;
      idx_q     <= '0;
      gap_cnt_q <= '0;
    end else begin
      if (accept) begin
        pat_q     <= pattern;
        reps_q    <= reps;
        gap_q     <= gap;
        gap_bit_q <= gap_bit;
      end
      if (clr_sent)      sent_q <= '0;
      else if (inc_sent) sent_q <= sent_q + 1'b1;
      if (idx_load)      idx_q <= LAST_IDX;
      else if (sh_shift) idx_q <= idx_q - 1'b1;
      if (gap_load)      gap_cnt_q <= gap_q;
      else if (gap_dec)  gap_cnt_q <= gap_cnt_q - 1'b1;
    end
  end

  always_comb begin
    dout   = IDLE_BIT;
    dvalid = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      SHIFT: begin
        dout   = sh_msb;
        dvalid = 1'b1;
        busy   = 1'b1;
      end
      GAP: begin
        dout = gap_bit_q;
        busy = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign sent_cnt = sent_q;

endmodule

// File: tb/tb_pattern_seq_tx.sv
// Randomized self-checking bench for pattern_seq_tx against a per-cycle burst model.
module tb_pattern_seq_tx;

  localparam int unsigned W        = 4;
  localparam logic        IDLE_BIT = 1'b0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] pattern = '0;
  logic [7:0]   reps = '0;
  logic [3:0]   gap = '0;
  logic         gap_bit = 1'b0;
  logic         dout, dvalid, busy, done;
  logic [7:0]   sent_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pattern_seq_tx #(.W(W), .IDLE_BIT(IDLE_BIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .pattern  (pattern),
    .reps     (reps),
    .gap      (gap),
    .gap_bit  (gap_bit),
    .dout     (dout),
    .dvalid   (dvalid),
    .busy     (busy),
    .done     (done),
    .sent_cnt (sent_cnt)
  );

  // One expected output cycle; rep_end marks the last bit of a repetition.
  typedef struct packed {
    logic dout;
    logic dvalid;
    logic busy;
    logic done;
    logic rep_end;
  } beat_t;

  beat_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Burst = reps copies of the pattern MSB-first, gap bits between copies, then one done cycle.
  task automatic build(input logic [W-1:0] p, input int unsigned r, input int unsigned g, input logic gb);
    exp_q.delete();
    for (int unsigned i = 0; i < r; i++) begin
      for (int unsigned b = 0; b < W; b++)
        exp_q.push_back(beat_t'{p[W-1-b], 1'b1, 1'b1, 1'b0, (b == W-1)});
      if (i + 1 < r)
        for (int unsigned k = 0; k < g; k++)
          exp_q.push_back(beat_t'{gb, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    exp_q.push_back(beat_t'{IDLE_BIT, 1'b0, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic check_idle(input string tag, input logic [7:0] cnt);
    check({tag, ".dout"},   32'(dout),     32'(IDLE_BIT));
    check({tag, ".dvalid"}, 32'(dvalid),   32'd0);
    check({tag, ".busy"},   32'(busy),     32'd0);
    check({tag, ".done"},   32'(done),     32'd0);
    check({tag, ".sent"},   32'(sent_cnt), 32'(cnt));
  endtask

  // Entered at cycle 1 of a burst; abort_at (1-based cycle, 0 = none) raises abort in that cycle.
  task automatic play(input string tag, input int unsigned abort_at, input int unsigned r, input bit scramble);
    int unsigned done_reps;
    done_reps = 0;
    for (int unsigned k = 0; k < exp_q.size(); k++) begin
      if (k == 0 && scramble) begin
        pattern = W'($urandom);
        reps    = 8'($urandom);
        gap     = 4'($urandom);
        gap_bit = 1'($urandom);
      end
      check({tag, ".dout"},   32'(dout),     32'(exp_q[k].dout));
      check({tag, ".dvalid"}, 32'(dvalid),   32'(exp_q[k].dvalid));
      check({tag, ".busy"},   32'(busy),     32'(exp_q[k].busy));
      check({tag, ".done"},   32'(done),     32'(exp_q[k].done));
      check({tag, ".sent"},   32'(sent_cnt), 32'(done_reps));
      if (abort_at == k + 1) begin
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        check_idle({tag, ".abort"}, 8'(done_reps));
        next_cycle();
        check_idle({tag, ".post_abort"}, 8'(done_reps));
        return;
      end
      if (exp_q[k].rep_end) done_reps++;
      next_cycle();
    end
    check_idle({tag, ".end"}, 8'(r));
  endtask

  task automatic launch(input logic [W-1:0] p, input int unsigned r, input int unsigned g, input logic gb);
    pattern = p;
    reps    = 8'(r);
    gap     = 4'(g);
    gap_bit = gb;
    start   = 1'b1;
    build(p, r, g, gb);
    next_cycle();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #2 check_idle("por", 8'd0);
    @(negedge clk) rst = 1'b0;
    next_cycle();
    check_idle("por_rel", 8'd0);

    launch(4'b1011, 1, 0, 1'b0);
    play("basic", 0, 1, 1'b1);

    launch(4'b1011, 3, 0, 1'b0);
    play("contig", 0, 3, 1'b1);

    launch(4'b1101, 2, 2, 1'b0);
    play("gap", 0, 2, 1'b1);

    launch(4'b1111, 0, 3, 1'b1);
    play("reps0", 0, 0, 1'b1);

    // start held high: second burst is accepted in the idle cycle after done
    pattern = 4'b1001; reps = 8'd2; gap = 4'd1; gap_bit = 1'b1; start = 1'b1;
    build(4'b1001, 2, 1, 1'b1);
    next_cycle();
    play("hold1", 0, 2, 1'b0);
    next_cycle();
    start = 1'b0;
    play("hold2", 0, 2, 1'b0);

    launch(4'b0110, 4, 1, 1'b1);
    play("abort", W + 1 + 2, 4, 1'b1);

    // abort beats start while idle
    start = 1'b1; abort = 1'b1; reps = 8'd2;
    next_cycle();
    start = 1'b0; abort = 1'b0;
    check_idle("idle_abort", 8'd1);

    // asynchronous reset three cycles into a burst
    launch(4'b1011, 4, 1, 1'b0);
    next_cycle();
    next_cycle();
    #2 rst = 1'b1;
    #1 check_idle("rst_mid", 8'd0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_idle("rst_after", 8'd0);
    end

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] p;
      int unsigned  r, g, ab;
      logic         gb;
      p  = W'($urandom);
      r  = $urandom_range(0, 6);
      g  = $urandom_range(0, 3);
      gb = 1'($urandom);
      launch(p, r, g, gb);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, exp_q.size()) : 0;
      play("rand", ab, r, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
